// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline control in, memory address and IF/ID bundle out.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] if_instr;
    logic [WIDTH-1:0] if_pc;
    logic             if_valid;
    logic             halted;
    logic [WIDTH-1:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_target, mem_data,
        output pc_out, if_instr, if_pc, if_valid, halted, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target, mem_data,
        input  pc_out, if_instr, if_pc, if_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures memory words into IF/ID,
// handles stall, branch redirect and end-of-program halt.
module fetch_unit #(
    parameter int WIDTH               = 32,
    parameter int INSTRACTION_NUMBERS = 16,
    parameter int RESET_PC            = 0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [WIDTH-1:0] LP_N    = WIDTH'(INSTRACTION_NUMBERS);
    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(INSTRACTION_NUMBERS - 1);
    localparam logic [WIDTH-1:0] LP_RST  = WIDTH'(RESET_PC);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_ipc;
    logic             r_valid;
    logic [WIDTH-1:0] r_count;

    state_t           w_state;
    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_instr;
    logic [WIDTH-1:0] w_ipc;
    logic             w_valid;
    logic [WIDTH-1:0] w_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_pc    <= LP_RST;
            r_instr <= '0;
            r_ipc   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_instr <= w_instr;
            r_ipc   <= w_ipc;
            r_valid <= w_valid;
            r_count <= w_count;
        end
    end

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_instr = r_instr;
        w_ipc   = r_ipc;
        w_valid = r_valid;
        w_count = r_count;
        unique case (r_state)
            S_RUN: begin
                // Only an out-of-range reset PC can reach this branch.
                if (r_pc >= LP_N) begin
                    w_state = S_HALT;
                    w_valid = 1'b0;
                end else if (bus.branch_taken) begin
                    w_valid = 1'b0;
                    w_instr = '0;
                    if (bus.branch_target < LP_N) begin
                        w_pc = bus.branch_target;
                    end else begin
                        w_state = S_HALT;
                    end
                end else if (!bus.stall) begin
                    w_instr = bus.mem_data;
                    w_ipc   = r_pc;
                    w_valid = 1'b1;
                    w_count = r_count + 1'b1;
                    if (r_pc == LP_LAST) begin
                        w_state = S_HALT;
                    end else begin
                        w_pc = r_pc + 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (!bus.stall) begin
                    w_valid = 1'b0;
                end
            end
            default: begin
                w_state = S_HALT;
            end
        endcase
    end

    assign bus.pc_out      = r_pc;
    assign bus.if_instr    = r_instr;
    assign bus.if_pc       = r_ipc;
    assign bus.if_valid    = r_valid;
    assign bus.halted      = (r_state == S_HALT);
    assign bus.fetch_count = r_count;
endmodule
